// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer types and sizing constants used by dispatch/rename,
// the reservation stations and the reorder buffer itself.
package reorder_buffer_pkg;

    localparam int DEFAULT_ROB_DEPTH      = 32;
    localparam int DEFAULT_ROB_IDX_WIDTH  = $clog2(DEFAULT_ROB_DEPTH);
    localparam int DEFAULT_PREG_IDX_WIDTH = 6;

    // Packet handed over by dispatch/rename for every renamed instruction.
    typedef struct packed {
        logic [4:0]                        areg_index;
        logic [DEFAULT_PREG_IDX_WIDTH-1:0] preg_index;
        logic [31:0]                       target_pc;
        logic                              branch_taken;
    } rob_packet_t;

    // One reorder-buffer slot.
    typedef struct packed {
        logic                              valid;
        logic                              done;
        logic                              mispredict;
        logic [4:0]                        areg;
        logic [DEFAULT_PREG_IDX_WIDTH-1:0] preg;
        logic [31:0]                       target_pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Allocates at the tail, marks entries done
// from the CDB, retires one entry per cycle from the head and raises the
// pipeline flush when a mispredicted branch retires.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH      = DEFAULT_ROB_DEPTH,
    parameter int ROB_IDX_WIDTH  = $clog2(ROB_DEPTH),
    parameter int PREG_IDX_WIDTH = DEFAULT_PREG_IDX_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      enqueue_rob_packet,
    input  rob_packet_t               rob_packet,
    output logic [ROB_IDX_WIDTH-1:0]  rob_index,
    output logic                      rob_full,
    output logic                      rob_empty,

    input  logic                      cdb_valid,
    input  logic [ROB_IDX_WIDTH-1:0]  cdb_rob_index,
    input  logic                      cdb_is_branch,
    input  logic                      cdb_mispredict,
    input  logic [31:0]               cdb_target_pc,

    output logic                      commit_valid,
    output logic [4:0]                commit_areg,
    output logic [PREG_IDX_WIDTH-1:0] commit_preg,
    output logic                      commit_we,
    output logic [ROB_IDX_WIDTH-1:0]  commit_rob_index,
    output logic                      branch_flush,
    output logic [31:0]               flush_pc
);

    localparam int PTR_WIDTH = ROB_IDX_WIDTH + 1;

    rob_entry_t               rob_mem [ROB_DEPTH];
    rob_entry_t               head_entry;
    logic [PTR_WIDTH-1:0]     head_ptr;
    logic [PTR_WIDTH-1:0]     tail_ptr;
    logic [ROB_IDX_WIDTH-1:0] head_idx;
    logic [ROB_IDX_WIDTH-1:0] tail_idx;
    logic                     do_enqueue;
    logic                     do_complete;

    // The prediction bit is not needed after rename; the CDB carries the
    // resolved outcome instead.
    logic unused_branch_taken;
    assign unused_branch_taken = rob_packet.branch_taken;

    assign head_idx   = head_ptr[ROB_IDX_WIDTH-1:0];
    assign tail_idx   = tail_ptr[ROB_IDX_WIDTH-1:0];
    assign head_entry = rob_mem[head_idx];

    // Wrap bit distinguishes full from empty when the index bits match.
    assign rob_empty = (head_ptr == tail_ptr);
    assign rob_full  = (head_idx == tail_idx) &&
                       (head_ptr[ROB_IDX_WIDTH] != tail_ptr[ROB_IDX_WIDTH]);
    assign rob_index = tail_idx;

    assign do_enqueue  = enqueue_rob_packet && !rob_full;
    assign do_complete = cdb_valid && rob_mem[cdb_rob_index].valid;

    // Commit outputs come straight off the head slot; payload is masked when
    // nothing retires so stale slot contents never leak out.
    assign commit_valid     = head_entry.valid && head_entry.done;
    assign commit_areg      = commit_valid ? head_entry.areg : 5'd0;
    assign commit_preg      = commit_valid ? PREG_IDX_WIDTH'(head_entry.preg) : '0;
    assign commit_we        = commit_valid && (head_entry.areg != 5'd0);
    assign commit_rob_index = head_idx;
    assign branch_flush     = commit_valid && head_entry.mispredict;
    assign flush_pc         = branch_flush ? head_entry.target_pc : 32'd0;

    // Head/tail pointer update; a retiring mispredict rewinds both to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else if (branch_flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (commit_valid) begin
                head_ptr <= head_ptr + PTR_WIDTH'(1);
            end
            if (do_enqueue) begin
                tail_ptr <= tail_ptr + PTR_WIDTH'(1);
            end
        end
    end

    // Entry storage: allocate at tail, complete from CDB, release at head.
    // Tail and head never alias while an enqueue and a commit coincide, and
    // the CDB only touches valid slots, so the three writes cannot collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_mem[i] <= '0;
            end
        end else if (branch_flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_mem[i].valid <= 1'b0;
            end
        end else begin
            if (commit_valid) begin
                rob_mem[head_idx].valid <= 1'b0;
            end
            if (do_complete) begin
                rob_mem[cdb_rob_index].done <= 1'b1;
                if (cdb_is_branch) begin
                    rob_mem[cdb_rob_index].mispredict <= cdb_mispredict;
                    rob_mem[cdb_rob_index].target_pc  <= cdb_target_pc;
                end
            end
            if (do_enqueue) begin
                rob_mem[tail_idx] <= '{valid:      1'b1,
                                       done:       1'b0,
                                       mispredict: 1'b0,
                                       areg:       rob_packet.areg_index,
                                       preg:       rob_packet.preg_index,
                                       target_pc:  rob_packet.target_pc};
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic, checked by a negedge monitor against a window/count-based model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int D = 32;

    logic        clk;
    logic        rst;
    logic        enqueue_rob_packet;
    rob_packet_t rob_packet;
    logic [4:0]  rob_index;
    logic        rob_full;
    logic        rob_empty;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_index;
    logic        cdb_is_branch;
    logic        cdb_mispredict;
    logic [31:0] cdb_target_pc;
    logic        commit_valid;
    logic [4:0]  commit_areg;
    logic [5:0]  commit_preg;
    logic        commit_we;
    logic [4:0]  commit_rob_index;
    logic        branch_flush;
    logic [31:0] flush_pc;

    reorder_buffer #(.ROB_DEPTH(D), .ROB_IDX_WIDTH(5), .PREG_IDX_WIDTH(6)) dut (
        .clk                (clk),
        .rst                (rst),
        .enqueue_rob_packet (enqueue_rob_packet),
        .rob_packet         (rob_packet),
        .rob_index          (rob_index),
        .rob_full           (rob_full),
        .rob_empty          (rob_empty),
        .cdb_valid          (cdb_valid),
        .cdb_rob_index      (cdb_rob_index),
        .cdb_is_branch      (cdb_is_branch),
        .cdb_mispredict     (cdb_mispredict),
        .cdb_target_pc      (cdb_target_pc),
        .commit_valid       (commit_valid),
        .commit_areg        (commit_areg),
        .commit_preg        (commit_preg),
        .commit_we          (commit_we),
        .commit_rob_index   (commit_rob_index),
        .branch_flush       (branch_flush),
        .flush_pc           (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: program-order window [m_head, m_head+m_count) over D slots.
    typedef struct {
        int         idx;
        logic [4:0] areg;
        logic [5:0] preg;
    } exp_t;

    exp_t        exp_q[$];
    int          m_head, m_tail, m_count;
    bit          m_done [D];
    bit          m_mis  [D];
    logic [31:0] m_tgt  [D];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_window(input int i);
        return ((i - m_head + D) % D) < m_count;
    endfunction

    task automatic model_reset();
        m_head  = 0;
        m_tail  = 0;
        m_count = 0;
        exp_q.delete();
        for (int i = 0; i < D; i++) begin
            m_done[i] = 0;
            m_mis[i]  = 0;
            m_tgt[i]  = 32'd0;
        end
    endtask

    // Drive one cycle of stimulus, let the edge happen, advance the model.
    task automatic step(input bit enq, input rob_packet_t pkt,
                        input bit cv, input int ci, input bit cb, input bit cm,
                        input logic [31:0] ct);
        bit commit_now;
        int pre_count;
        enqueue_rob_packet = enq;
        rob_packet         = pkt;
        cdb_valid          = cv;
        cdb_rob_index      = 5'(ci);
        cdb_is_branch      = cb;
        cdb_mispredict     = cm;
        cdb_target_pc      = ct;
        @(posedge clk);
        commit_now = (m_count > 0) && m_done[m_head];
        pre_count  = m_count;
        if (commit_now && m_mis[m_head]) begin
            m_head  = 0;
            m_tail  = 0;
            m_count = 0;
        end else begin
            if (cv && in_window(ci % D)) begin
                m_done[ci % D] = 1;
                if (cb) begin
                    m_mis[ci % D] = cm;
                    m_tgt[ci % D] = ct;
                end
            end
            if (commit_now) begin
                m_head  = (m_head + 1) % D;
                m_count = m_count - 1;
            end
            if (enq && pre_count < D) begin
                m_done[m_tail] = 0;
                m_mis[m_tail]  = 0;
                m_tgt[m_tail]  = pkt.target_pc;
                exp_q.push_back('{idx: m_tail, areg: pkt.areg_index, preg: pkt.preg_index});
                m_tail  = (m_tail + 1) % D;
                m_count = m_count + 1;
            end
        end
        #1;
    endtask

    function automatic rob_packet_t mk(input int a, input int p, input logic [31:0] t);
        return '{areg_index: 5'(a), preg_index: 6'(p), target_pc: t, branch_taken: 1'b0};
    endfunction

    task automatic do_enq(input int a, input int p);
        step(1, mk(a, p, 32'h1000_0000 + 32'(p)), 0, 0, 0, 0, 0);
    endtask

    task automatic do_cdb(input int i, input bit br, input bit mis, input logic [31:0] t);
        step(0, mk(0, 0, 0), 1, i, br, mis, t);
    endtask

    task automatic do_idle();
        step(0, mk(0, 0, 0), 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int ids[$];
        for (int k = 0; k < m_count; k++) ids.push_back((m_head + k) % D);
        foreach (ids[k]) do_cdb(ids[k], 0, 0, 0);
        for (int k = 0; k < D + 4 && m_count > 0; k++) do_idle();
        chk("drain_empty", rob_empty, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rob_index"}, rob_index, 0);
        chk({tag, "_rob_full"}, rob_full, 0);
        chk({tag, "_rob_empty"}, rob_empty, 1);
        chk({tag, "_commit_valid"}, commit_valid, 0);
        chk({tag, "_commit_we"}, commit_we, 0);
        chk({tag, "_branch_flush"}, branch_flush, 0);
        chk({tag, "_flush_pc"}, flush_pc, 0);
        chk({tag, "_commit_areg"}, commit_areg, 0);
        chk({tag, "_commit_preg"}, commit_preg, 0);
        chk({tag, "_commit_rob_index"}, commit_rob_index, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst                = 1'b1;
        enqueue_rob_packet = 1'b0;
        cdb_valid          = 1'b0;
        model_reset();
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every cycle compare status against the model and pop the
    // expected commit stream whenever the DUT retires.
    initial begin
        exp_t e;
        bit   exp_cv;
        forever begin
            @(negedge clk);
            exp_cv = (m_count > 0) && m_done[m_head];
            chk("rob_index", rob_index, m_tail);
            chk("rob_full", rob_full, m_count == D);
            chk("rob_empty", rob_empty, m_count == 0);
            chk("commit_valid", commit_valid, exp_cv);
            if (commit_valid && exp_cv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL commit_stream: commit seen with no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_rob_index", commit_rob_index, e.idx);
                    chk("commit_areg", commit_areg, e.areg);
                    chk("commit_preg", commit_preg, e.preg);
                    chk("commit_we", commit_we, e.areg != 5'd0);
                    chk("branch_flush", branch_flush, m_mis[e.idx]);
                    if (m_mis[e.idx]) begin
                        chk("flush_pc", flush_pc, m_tgt[e.idx]);
                        exp_q.delete();
                    end
                end
            end else begin
                chk("commit_we_idle", commit_we, 0);
                chk("branch_flush_idle", branch_flush, 0);
            end
        end
    end

    initial begin
        int enq_pct, cdb_pct, ci;
        bit br, mis;

        rst                = 1'b1;
        enqueue_rob_packet = 1'b0;
        rob_packet         = '0;
        cdb_valid          = 1'b0;
        cdb_rob_index      = '0;
        cdb_is_branch      = 1'b0;
        cdb_mispredict     = 1'b0;
        cdb_target_pc      = '0;
        model_reset();
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // In-order commit despite out-of-order completion.
        do_enq(1, 33);
        do_enq(2, 34);
        do_enq(3, 35);
        do_cdb(2, 0, 0, 0);
        do_idle();
        do_cdb(0, 0, 0, 0);
        do_cdb(1, 0, 0, 0);
        do_idle();
        do_idle();
        chk("inorder_empty", rob_empty, 1);

        // Fill to full, reject the overflow, commit while full, then wrap.
        async_reset("rst_fill");
        for (int k = 0; k < D + 1; k++) do_enq((k % 31) + 1, k);
        chk("full_after_fill", rob_full, 1);
        do_cdb(0, 0, 0, 0);
        do_enq(9, 60);
        do_enq(10, 61);
        chk("wrap_full_again", rob_full, 1);
        drain();

        // Mispredicted branch at index 1 with younger entries behind it.
        async_reset("rst_branch");
        for (int k = 0; k < 5; k++) do_enq(k + 4, k + 40);
        do_cdb(1, 1, 1, 32'h6000_0040);
        do_cdb(3, 0, 0, 0);
        do_cdb(0, 0, 0, 0);
        do_idle();
        do_idle();
        chk("flush_empty", rob_empty, 1);
        chk("flush_index", rob_index, 0);

        // Architectural register 0 retires without a write enable.
        do_enq(0, 7);
        do_cdb(0, 0, 0, 0);
        do_idle();
        do_idle();

        // Reset with ten live entries.
        for (int k = 0; k < 10; k++) do_enq(k + 1, k + 20);
        do_cdb(0, 0, 0, 0);
        async_reset("rst_mid");
        do_enq(5, 5);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                enq_pct = $urandom_range(20, 95);
                cdb_pct = $urandom_range(10, 90);
            end
            ci  = (m_count > 0) ? (m_head + $urandom_range(0, m_count - 1)) % D : 0;
            if ($urandom_range(0, 9) == 0) ci = $urandom_range(0, D - 1);
            br  = ($urandom_range(0, 99) < 30);
            mis = br && ($urandom_range(0, 99) < 15);
            step($urandom_range(0, 99) < enq_pct,
                 mk($urandom_range(0, 31), $urandom_range(0, 63), $urandom),
                 $urandom_range(0, 99) < cdb_pct, ci, br, mis, $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
